// File: rtl/rv_wb_arb_pkg.sv
// rtl/rv_wb_arb_pkg.sv - shared widths, types and helpers for the register-file write arbiter
package rv_wb_arb_pkg;

    localparam int XLEN    = 32;
    localparam int RV_NREG = 32;
    localparam int RV_REGW = 5;

    typedef logic [RV_REGW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_PIPE = 2'd1,
        WB_LL   = 2'd2
    } wb_src_e;

    // x0 is hardwired to zero, so it is never a real write target
    function automatic logic is_wr_target(input reg_idx_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// rtl/rv_wb_fifo.sv - synchronous FIFO holding long-latency results awaiting an RF write slot
module rv_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 37,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_comb begin
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o      = mem_q[rptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/rv_wb_arb.sv
// rtl/rv_wb_arb.sv - register-file write-port arbiter with long-latency buffer and busy scoreboard
module rv_wb_arb
    import rv_wb_arb_pkg::*;
#(
    parameter int LL_DEPTH = 2,
    parameter int MXLEN    = XLEN,
    parameter int CW       = $clog2(LL_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pipe_we_i,
    input  logic [4:0]       pipe_rd_i,
    input  logic [MXLEN-1:0] pipe_data_i,
    input  logic             ll_valid_i,
    output logic             ll_ready_o,
    input  logic [4:0]       ll_rd_i,
    input  logic [MXLEN-1:0] ll_data_i,
    input  logic             iss_valid_i,
    input  logic [4:0]       iss_rd_i,
    input  logic [4:0]       dec_rs1_i,
    input  logic [4:0]       dec_rs2_i,
    input  logic [4:0]       dec_rd_i,
    output logic             hz_stall_o,
    output logic [CW-1:0]    ll_pend_o,
    output logic             rf_wr_en_o,
    output logic [4:0]       rf_wr_reg_o,
    output logic [MXLEN-1:0] rf_wr_data_o
);

    localparam int DW = RV_REGW + MXLEN;

    logic [RV_NREG-1:0] busy_q, busy_d;
    logic               ready_q, ready_d;

    logic               pipe_act, push, pop;
    logic               fifo_full, fifo_empty;
    logic [DW-1:0]      head;
    reg_idx_t           head_rd;
    logic [MXLEN-1:0]   head_data;
    logic [CW-1:0]      count, count_next;
    wb_src_e            src;

    assign pipe_act = pipe_we_i && is_wr_target(pipe_rd_i);
    assign pop      = !pipe_act && !fifo_empty;
    assign push     = ll_valid_i && ready_q;

    rv_wb_fifo #(
        .DEPTH (LL_DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (push),
        .wdata_i      ({ll_rd_i, ll_data_i}),
        .pop_i        (pop),
        .rdata_o      (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (count),
        .count_next_o (count_next)
    );

    assign head_rd   = head[DW-1 -: RV_REGW];
    assign head_data = head[MXLEN-1:0];

    // Pipeline writebacks own the port; buffered results only use idle slots
    always_comb begin
        src = WB_NONE;
        if (pipe_act) begin
            src = WB_PIPE;
        end else if (pop && is_wr_target(head_rd)) begin
            src = WB_LL;
        end
    end

    always_comb begin
        rf_wr_en_o   = 1'b0;
        rf_wr_reg_o  = '0;
        rf_wr_data_o = '0;
        case (src)
            WB_PIPE: begin
                rf_wr_en_o   = 1'b1;
                rf_wr_reg_o  = pipe_rd_i;
                rf_wr_data_o = pipe_data_i;
            end
            WB_LL: begin
                rf_wr_en_o   = 1'b1;
                rf_wr_reg_o  = head_rd;
                rf_wr_data_o = head_data;
            end
            default: ;
        endcase
    end

    // Clear before set so a re-issue to the register being retired keeps it busy
    always_comb begin
        busy_d = busy_q;
        if (pop && is_wr_target(head_rd)) begin
            busy_d[head_rd] = 1'b0;
        end
        if (iss_valid_i && is_wr_target(iss_rd_i)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign ready_d = (count_next < CW'(LL_DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign hz_stall_o = busy_q[dec_rs1_i] | busy_q[dec_rs2_i] | busy_q[dec_rd_i];
    assign ll_ready_o = ready_q;
    assign ll_pend_o  = count;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_rv_wb_arb.sv
// tb/tb_rv_wb_arb.sv - directed self-checking bench for rv_wb_arb with a queue-based reference model
module tb_rv_wb_arb;

    localparam int DEPTH = 2;
    localparam int XL    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          pipe_we_i;
    logic [4:0]    pipe_rd_i;
    logic [XL-1:0] pipe_data_i;
    logic          ll_valid_i;
    logic          ll_ready_o;
    logic [4:0]    ll_rd_i;
    logic [XL-1:0] ll_data_i;
    logic          iss_valid_i;
    logic [4:0]    iss_rd_i;
    logic [4:0]    dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic          hz_stall_o;
    logic [CW-1:0] ll_pend_o;
    logic          rf_wr_en_o;
    logic [4:0]    rf_wr_reg_o;
    logic [XL-1:0] rf_wr_data_o;

    rv_wb_arb #(.LL_DEPTH(DEPTH), .MXLEN(XL)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pipe_we_i    (pipe_we_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_data_i  (pipe_data_i),
        .ll_valid_i   (ll_valid_i),
        .ll_ready_o   (ll_ready_o),
        .ll_rd_i      (ll_rd_i),
        .ll_data_i    (ll_data_i),
        .iss_valid_i  (iss_valid_i),
        .iss_rd_i     (iss_rd_i),
        .dec_rs1_i    (dec_rs1_i),
        .dec_rs2_i    (dec_rs2_i),
        .dec_rd_i     (dec_rd_i),
        .hz_stall_o   (hz_stall_o),
        .ll_pend_o    (ll_pend_o),
        .rf_wr_en_o   (rf_wr_en_o),
        .rf_wr_reg_o  (rf_wr_reg_o),
        .rf_wr_data_o (rf_wr_data_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]    rd;
        logic [XL-1:0] data;
    } ent_t;

    ent_t     mq[$];
    bit [31:0] mbusy;
    bit        mready;

    // Reference model: outputs checked mid-cycle, state advanced at the rising edge
    initial begin : model
        bit         do_pop, do_push, do_iss, r_at_neg;
        ent_t       e, h;
        logic       x_en;
        logic [4:0] x_reg;
        logic [XL-1:0] x_data;
        mq.delete();
        mbusy  = '0;
        mready = 1'b0;
        forever begin
            @(negedge clk);
            r_at_neg = rstn;
            if (!rstn) begin
                mq.delete();
                mbusy  = '0;
                mready = 1'b0;
            end
            x_en = 1'b0; x_reg = '0; x_data = '0;
            do_pop = 1'b0;
            if (pipe_we_i && pipe_rd_i != 0) begin
                x_en = 1'b1; x_reg = pipe_rd_i; x_data = pipe_data_i;
            end else if (mq.size() > 0) begin
                do_pop = 1'b1;
                h = mq[0];
                if (h.rd != 0) begin
                    x_en = 1'b1; x_reg = h.rd; x_data = h.data;
                end
            end
            chk("wr_en",   64'(rf_wr_en_o),   64'(x_en));
            chk("wr_reg",  64'(rf_wr_reg_o),  64'(x_reg));
            chk("wr_data", 64'(rf_wr_data_o), 64'(x_data));
            chk("pend",    64'(ll_pend_o),    64'(mq.size()));
            chk("ready",   64'(ll_ready_o),   64'(mready));
            chk("stall",   64'(hz_stall_o),
                64'(mbusy[dec_rs1_i] | mbusy[dec_rs2_i] | mbusy[dec_rd_i]));
            do_push = ll_valid_i && mready;
            do_iss  = iss_valid_i && iss_rd_i != 0;
            e.rd = ll_rd_i; e.data = ll_data_i;
            @(posedge clk);
            if (rstn && r_at_neg) begin
                if (do_pop) begin
                    h = mq.pop_front();
                    if (h.rd != 0) mbusy[h.rd] = 1'b0;
                end
                if (do_iss) mbusy[iss_rd_i] = 1'b1;
                if (do_push) mq.push_back(e);
                mready = (mq.size() < DEPTH);
            end else if (rstn) begin
                mready = (mq.size() < DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin : stim
        rstn = 1'b0;
        pipe_we_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
        ll_valid_i = 0; ll_rd_i = 0; ll_data_i = 0;
        iss_valid_i = 0; iss_rd_i = 0;
        dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0;

        // 1: reset release with no traffic
        tick(); tick();
        chk("t1_ready_in_reset", 64'(ll_ready_o), 64'd0);
        rstn = 1'b1;
        settle();
        chk("t1_ready_before_edge", 64'(ll_ready_o), 64'd0);
        tick(); settle();
        chk("t1_ready_after_edge", 64'(ll_ready_o), 64'd1);
        chk("t1_wr_en", 64'(rf_wr_en_o), 64'd0);
        chk("t1_pend", 64'(ll_pend_o), 64'd0);

        // 2: zero-latency pipeline writeback, then a write to x0
        tick();
        pipe_we_i = 1; pipe_rd_i = 5; pipe_data_i = 32'hDEADBEEF;
        settle();
        chk("t2_en", 64'(rf_wr_en_o), 64'd1);
        chk("t2_reg", 64'(rf_wr_reg_o), 64'd5);
        chk("t2_data", 64'(rf_wr_data_o), 64'hDEADBEEF);
        tick();
        pipe_rd_i = 0;
        settle();
        chk("t2_x0_en", 64'(rf_wr_en_o), 64'd0);
        tick();
        pipe_we_i = 0;

        // 3: issue, stall, long-latency return, stall release
        iss_valid_i = 1; iss_rd_i = 7; dec_rs1_i = 7;
        settle();
        chk("t3_stall_not_yet", 64'(hz_stall_o), 64'd0);
        tick();
        iss_valid_i = 0;
        ll_valid_i = 1; ll_rd_i = 7; ll_data_i = 32'h1234;
        settle();
        chk("t3_stall_busy", 64'(hz_stall_o), 64'd1);
        chk("t3_no_bypass", 64'(rf_wr_en_o), 64'd0);
        tick();
        ll_valid_i = 0;
        settle();
        chk("t3_ll_en", 64'(rf_wr_en_o), 64'd1);
        chk("t3_ll_reg", 64'(rf_wr_reg_o), 64'd7);
        chk("t3_ll_data", 64'(rf_wr_data_o), 64'h1234);
        chk("t3_stall_still", 64'(hz_stall_o), 64'd1);
        tick(); settle();
        chk("t3_stall_cleared", 64'(hz_stall_o), 64'd0);
        dec_rs1_i = 0;

        // 4: pipe occupies the port, FIFO fills, then drains in order
        tick();
        pipe_we_i = 1; pipe_rd_i = 1; pipe_data_i = 32'h11;
        ll_valid_i = 1; ll_rd_i = 10; ll_data_i = 32'hA;
        tick();
        pipe_data_i = 32'h12;
        ll_rd_i = 11; ll_data_i = 32'hB;
        tick();
        pipe_data_i = 32'h13;
        ll_rd_i = 12; ll_data_i = 32'hC;
        settle();
        chk("t4_full_ready", 64'(ll_ready_o), 64'd0);
        chk("t4_full_pend", 64'(ll_pend_o), 64'd2);
        chk("t4_pipe_wins", 64'(rf_wr_reg_o), 64'd1);
        tick();
        pipe_we_i = 0;
        settle();
        chk("t4_held_pend", 64'(ll_pend_o), 64'd2);
        chk("t4_drain0_reg", 64'(rf_wr_reg_o), 64'd10);
        chk("t4_drain0_data", 64'(rf_wr_data_o), 64'hA);
        tick(); settle();
        chk("t4_ready_back", 64'(ll_ready_o), 64'd1);
        chk("t4_drain1_reg", 64'(rf_wr_reg_o), 64'd11);
        tick();
        ll_valid_i = 0;
        settle();
        chk("t4_drain2_reg", 64'(rf_wr_reg_o), 64'd12);
        chk("t4_drain2_data", 64'(rf_wr_data_o), 64'hC);
        tick(); settle();
        chk("t4_empty_en", 64'(rf_wr_en_o), 64'd0);
        chk("t4_empty_pend", 64'(ll_pend_o), 64'd0);

        // 5: retire and re-issue of x9 in the same cycle, plus an x0 entry
        tick();
        iss_valid_i = 1; iss_rd_i = 9;
        tick();
        iss_valid_i = 0;
        ll_valid_i = 1; ll_rd_i = 9; ll_data_i = 32'h99;
        tick();
        ll_valid_i = 0;
        iss_valid_i = 1; iss_rd_i = 9; dec_rs2_i = 9;
        settle();
        chk("t5_pop_reg", 64'(rf_wr_reg_o), 64'd9);
        tick();
        iss_valid_i = 0;
        settle();
        chk("t5_set_wins", 64'(hz_stall_o), 64'd1);
        ll_valid_i = 1; ll_rd_i = 0; ll_data_i = 32'h5555;
        tick();
        ll_valid_i = 0;
        settle();
        chk("t5_x0_pend", 64'(ll_pend_o), 64'd1);
        chk("t5_x0_en", 64'(rf_wr_en_o), 64'd0);
        tick(); settle();
        chk("t5_x0_popped", 64'(ll_pend_o), 64'd0);
        ll_valid_i = 1; ll_rd_i = 9; ll_data_i = 32'h77;
        tick();
        ll_valid_i = 0;
        tick(); settle();
        chk("t5_cleared", 64'(hz_stall_o), 64'd0);
        dec_rs2_i = 0;

        // 6: asynchronous reset with a full FIFO and two busy registers
        tick();
        pipe_we_i = 1; pipe_rd_i = 1; pipe_data_i = 32'h21;
        iss_valid_i = 1; iss_rd_i = 3;
        tick();
        iss_rd_i = 4;
        tick();
        iss_valid_i = 0;
        ll_valid_i = 1; ll_rd_i = 3; ll_data_i = 32'h33;
        tick();
        ll_rd_i = 4; ll_data_i = 32'h44;
        tick();
        ll_valid_i = 0;
        dec_rs1_i = 3; dec_rs2_i = 4;
        settle();
        chk("t6_full", 64'(ll_pend_o), 64'd2);
        chk("t6_busy", 64'(hz_stall_o), 64'd1);
        tick();
        pipe_we_i = 0;
        rstn = 1'b0;
        settle();
        chk("t6_rst_pend", 64'(ll_pend_o), 64'd0);
        chk("t6_rst_en", 64'(rf_wr_en_o), 64'd0);
        chk("t6_rst_busy", 64'(hz_stall_o), 64'd0);
        chk("t6_rst_ready", 64'(ll_ready_o), 64'd0);
        tick();
        rstn = 1'b1;
        tick(); settle();
        chk("t6_post_en", 64'(rf_wr_en_o), 64'd0);
        chk("t6_post_ready", 64'(ll_ready_o), 64'd1);
        chk("t6_post_busy", 64'(hz_stall_o), 64'd0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
